// File: rtl/tcdm_stream_loader_pkg.sv
// Shared types for the TCDM stream loader: FSM states, sampled control and status flags.
package tcdm_loader_package;

  localparam int unsigned WordWidth     = 32;
  localparam int unsigned StrbWidth     = WordWidth / 8;
  // Control fields are sized for the widest supported ADDR_WIDTH / LEN_WIDTH.
  localparam int unsigned CtrlAddrWidth = 32;
  localparam int unsigned CtrlLenWidth  = 16;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDrain,
    StDone
  } state_e;

  typedef struct packed {
    logic [CtrlAddrWidth-1:0] base_addr;
    logic [CtrlAddrWidth-1:0] stride;
    logic [CtrlLenWidth-1:0]  len;
  } ctrl_t;

  typedef struct packed {
    logic busy;
    logic done;
  } flags_t;

endpackage

// File: rtl/tcdm_stream_loader_if.sv
// TCDM request/response port and HWPE word stream used by the loader.
interface hwpe_stream_intf_tcdm;
  import tcdm_loader_package::*;

  logic                 req;
  logic                 gnt;
  logic [WordWidth-1:0] add;
  logic                 wen;
  logic [StrbWidth-1:0] be;
  logic [WordWidth-1:0] data;
  logic [WordWidth-1:0] r_data;
  logic                 r_valid;

  modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
  modport slave  (input req, add, wen, be, data, output gnt, r_data, r_valid);
endinterface

interface hwpe_stream_intf_stream;
  import tcdm_loader_package::*;

  logic                 valid;
  logic                 ready;
  logic [WordWidth-1:0] data;
  logic [StrbWidth-1:0] strb;

  modport source (output valid, data, strb, input ready);
  modport sink   (input valid, data, strb, output ready);
endinterface

// File: rtl/tcdm_loader_resp_fifo.sv
// Response buffer for TCDM read data; flop array with occupancy count, reset and clear aware.
module tcdm_loader_resp_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 32,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             full;

  assign full    = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      mem_q    <= '{default: '0};
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      // Pointers wrap naturally because Depth is a power of two.
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + CntW'(push_i) - CntW'(pop_i);
    end
  end

  push_when_full_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && full && !pop_i));

endmodule

// File: rtl/tcdm_stream_loader.sv
// Strided TCDM word reader feeding an HWPE stream with credit-based response buffering.
// Optional stall counter port enabled by TCDM_STREAM_LOADER_PERF_EN.
module tcdm_stream_loader
  import tcdm_loader_package::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  hwpe_stream_intf_tcdm.master   tcdm_load_master,
  hwpe_stream_intf_stream.source source_stream,
  input  logic                   start_i,
  input  logic [ADDR_WIDTH-1:0]  base_addr_i,
  input  logic [ADDR_WIDTH-1:0]  stride_i,
  input  logic [LEN_WIDTH-1:0]   len_i,
  output logic                   busy_o,
  output logic                   done_o
`ifdef TCDM_STREAM_LOADER_PERF_EN
  ,
  output logic [31:0]            stall_cycles_o
`endif
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  state_e                state_q;
  flags_t                flags_q;
  ctrl_t                 ctrl_in;
  logic [ADDR_WIDTH-1:0] addr_q, stride_q;
  logic [LEN_WIDTH-1:0]  len_q, req_cnt_q, pop_cnt_q;
  logic [CntW-1:0]       fifo_cnt, out_q, out_d, drop_q, drop_d;
  logic                  req, grant, resp_push, pop, credit_ok, fifo_empty;

  assign ctrl_in = '{base_addr: CtrlAddrWidth'(base_addr_i),
                     stride:    CtrlAddrWidth'(stride_i),
                     len:       CtrlLenWidth'(len_i)};

  assign credit_ok = ((CntW+1)'(fifo_cnt) + (CntW+1)'(out_q)) < (CntW+1)'(FIFO_DEPTH);
  // Hold off new requests until every response orphaned by a clear has drained.
  assign req       = (state_q == StLoad) && credit_ok && (drop_q == '0);
  assign grant     = req && tcdm_load_master.gnt;
  assign resp_push = tcdm_load_master.r_valid && (drop_q == '0) && !clear_i;
  assign pop       = source_stream.valid && source_stream.ready;

  assign tcdm_load_master.req  = req;
  assign tcdm_load_master.add  = WordWidth'({addr_q[ADDR_WIDTH-1:2], 2'b00});
  assign tcdm_load_master.wen  = 1'b1;
  assign tcdm_load_master.be   = '1;
  assign tcdm_load_master.data = '0;

  assign source_stream.valid = !fifo_empty;
  assign source_stream.strb  = '1;

  assign busy_o = flags_q.busy;
  assign done_o = flags_q.done;

  always_comb begin
    out_d  = out_q;
    drop_d = drop_q;
    if (clear_i) begin
      // Everything in flight, including a grant landing this cycle, becomes a drop.
      out_d  = '0;
      drop_d = drop_q + out_q + CntW'(grant) - CntW'(tcdm_load_master.r_valid);
    end else begin
      if ((drop_q != '0) && tcdm_load_master.r_valid) drop_d = drop_q - 1'b1;
      out_d = out_q + CntW'(grant) - CntW'(resp_push);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q  <= '0;
      drop_q <= '0;
    end else begin
      out_q  <= out_d;
      drop_q <= drop_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      flags_q   <= '0;
      addr_q    <= '0;
      stride_q  <= '0;
      len_q     <= '0;
      req_cnt_q <= '0;
      pop_cnt_q <= '0;
    end else if (clear_i) begin
      state_q   <= StIdle;
      flags_q   <= '0;
      addr_q    <= '0;
      stride_q  <= '0;
      len_q     <= '0;
      req_cnt_q <= '0;
      pop_cnt_q <= '0;
    end else begin
      flags_q.done <= 1'b0;
      if (pop) pop_cnt_q <= pop_cnt_q + 1'b1;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            flags_q.busy <= 1'b1;
            addr_q       <= ADDR_WIDTH'(ctrl_in.base_addr);
            stride_q     <= ADDR_WIDTH'(ctrl_in.stride);
            len_q        <= LEN_WIDTH'(ctrl_in.len);
            req_cnt_q    <= '0;
            pop_cnt_q    <= '0;
            state_q      <= (ctrl_in.len == '0) ? StDone : StLoad;
          end
        end
        StLoad: begin
          if (grant) begin
            addr_q    <= addr_q + stride_q;
            req_cnt_q <= req_cnt_q + 1'b1;
            if (req_cnt_q == len_q - 1'b1) state_q <= StDrain;
          end
        end
        StDrain: begin
          if (pop && (pop_cnt_q + 1'b1 == len_q)) state_q <= StDone;
        end
        StDone: begin
          flags_q <= '{busy: 1'b0, done: 1'b1};
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  tcdm_loader_resp_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (WordWidth)
  ) u_resp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (resp_push),
    .data_i  (tcdm_load_master.r_data),
    .pop_i   (pop),
    .data_o  (source_stream.data),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

`ifdef TCDM_STREAM_LOADER_PERF_EN
  logic [31:0] stall_q;
  logic        stall_evt;

  assign stall_evt = flags_q.busy && ((req && !tcdm_load_master.gnt) ||
                                      (source_stream.valid && !source_stream.ready));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= '0;
    end else if (clear_i || ((state_q == StIdle) && start_i)) begin
      stall_q <= '0;
    end else if (stall_evt && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cycles_o = stall_q;
`endif

endmodule

// File: tb/tb_tcdm_stream_loader.sv
// Scoreboard bench for tcdm_stream_loader: TCDM memory model, random gnt/ready, queued expectations.
module tb_tcdm_stream_loader;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        clear_i = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] base_addr_i = '0;
  logic [31:0] stride_i = '0;
  logic [15:0] len_i = '0;
  logic        busy_o, done_o;
`ifdef TCDM_STREAM_LOADER_PERF_EN
  logic [31:0] stall_cycles;
`endif

  hwpe_stream_intf_tcdm   tcdm_if ();
  hwpe_stream_intf_stream stream_if ();

  tcdm_stream_loader u_dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .clear_i          (clear_i),
    .tcdm_load_master (tcdm_if),
    .source_stream    (stream_if),
    .start_i          (start_i),
    .base_addr_i      (base_addr_i),
    .stride_i         (stride_i),
    .len_i            (len_i),
    .busy_o           (busy_o),
    .done_o           (done_o)
`ifdef TCDM_STREAM_LOADER_PERF_EN
    ,
    .stall_cycles_o   (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_addr_q [$];
  logic [31:0] exp_data_q [$];

  int          cyc = 0;
  int          gnt_pct = 100, ready_pct = 100, ready_hold = 0;
  logic        pend_rvalid = 1'b0;
  logic [31:0] pend_addr = '0;
  int          grants, pops, req_seen, done_cnt, done_cycle, busy_cnt, last_hs;
  int          max_inflight, stall_model;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
  endfunction

  // TCDM slave and stream sink drivers: change inputs just after the active edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    tcdm_if.r_valid = pend_rvalid;
    tcdm_if.r_data  = pend_rvalid ? mem_word(pend_addr) : 32'h0;
    tcdm_if.gnt     = int'($urandom_range(99)) < gnt_pct;
    if (ready_hold > 0) begin
      stream_if.ready = 1'b0;
      ready_hold--;
    end else begin
      stream_if.ready = int'($urandom_range(99)) < ready_pct;
    end
  end

  // Monitor on the inactive edge: grants, responses to schedule, stream handshakes.
  always @(negedge clk) begin
    pend_rvalid = 1'b0;
    if (rst_ni) begin
      if (tcdm_if.req) req_seen++;
      if (tcdm_if.req && tcdm_if.gnt) begin
        grants++;
        if (exp_addr_q.size() == 0) check_eq("extra_req", exp_addr_q.size(), 1);
        else check_eq("tcdm_addr", tcdm_if.add, exp_addr_q.pop_front());
        pend_rvalid = 1'b1;
        pend_addr   = tcdm_if.add;
      end
      if (stream_if.valid && stream_if.ready) begin
        pops++;
        last_hs = cyc;
        if (exp_data_q.size() == 0) check_eq("extra_beat", exp_data_q.size(), 1);
        else check_eq("stream_data", stream_if.data, exp_data_q.pop_front());
      end
      if (prev_stall) begin
        check_eq("hold_valid", stream_if.valid, 1);
        check_eq("hold_data", stream_if.data, prev_data);
      end
      prev_stall = stream_if.valid && !stream_if.ready && !clear_i;
      prev_data  = stream_if.data;
      if (done_o) begin
        done_cnt++;
        done_cycle = cyc;
      end
      if (busy_o) busy_cnt++;
      if (busy_o && ((tcdm_if.req && !tcdm_if.gnt) || (stream_if.valid && !stream_if.ready)))
        stall_model++;
      if (grants - pops > max_inflight) max_inflight = grants - pops;
    end
  end

  task automatic clear_stats();
    grants = 0; pops = 0; req_seen = 0; done_cnt = 0; done_cycle = -1;
    busy_cnt = 0; last_hs = -1; max_inflight = 0; stall_model = 0;
  endtask

  task automatic push_expect(input logic [31:0] base, input logic [31:0] stride, input int len);
    logic [31:0] a;
    a = base;
    for (int i = 0; i < len; i++) begin
      exp_addr_q.push_back(a);
      exp_data_q.push_back(mem_word(a));
      a = a + stride;
    end
  endtask

  task automatic pulse_start(input logic [31:0] base, input logic [31:0] stride, input int len,
                             output int c0);
    base_addr_i = base;
    stride_i    = stride;
    len_i       = 16'(len);
    start_i     = 1'b1;
    c0          = cyc;
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  task automatic run_xfer(input logic [31:0] base, input logic [31:0] stride, input int len,
                          input int max_cycles);
    int c0;
    clear_stats();
    push_expect(base, stride, len);
    pulse_start(base, stride, len, c0);
    for (int n = 0; n < max_cycles && done_cnt == 0; n++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check_eq("done_once", done_cnt, 1);
    check_eq("beats", pops, len);
    check_eq("done_lat", done_cycle, (len == 0) ? c0 + 2 : last_hs + 2);
    check_eq("busy_cycles", busy_cnt, done_cycle - c0 - 1);
    check_eq("data_left", exp_data_q.size(), 0);
    exp_addr_q.delete();
    exp_data_q.delete();
  endtask

  initial begin
    int c0;
    tcdm_if.gnt = 1'b0; tcdm_if.r_valid = 1'b0; tcdm_if.r_data = '0;
    stream_if.ready = 1'b0;
    clear_stats();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req", tcdm_if.req, 0);
    check_eq("rst_valid", stream_if.valid, 0);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_done", done_o, 0);
    @(posedge clk);
    #1 rst_ni = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Full-rate incrementing transfer.
    gnt_pct = 100; ready_pct = 100;
    run_xfer(32'h1000, 32'd4, 8, 200);

    // Negative stride with a long ready stall: credit must cap in-flight words.
    ready_hold = 10;
    run_xfer(32'h2000, 32'hFFFF_FFF8, 6, 200);
    check_eq("inflight_le_depth", max_inflight <= 4, 1);

    // Random grant and backpressure.
    gnt_pct = 50; ready_pct = 60;
    run_xfer(32'h4000, 32'd12, 100, 3000);

    // Zero-length transfer.
    gnt_pct = 100; ready_pct = 100;
    run_xfer(32'h1234, 32'd4, 0, 20);
    check_eq("len0_no_req", req_seen, 0);

    // Clear with two grants issued and one response still in flight.
    ready_pct = 0;
    clear_stats();
    push_expect(32'h2800, 32'd4, 8);
    pulse_start(32'h2800, 32'd4, 8, c0);
    @(posedge clk);
    #1 clear_i = 1'b1;
    @(posedge clk);
    #1 clear_i = 1'b0;
    exp_addr_q.delete();
    exp_data_q.delete();
    repeat (4) begin
      @(negedge clk);
      check_eq("clr_valid", stream_if.valid, 0);
      check_eq("clr_req", tcdm_if.req, 0);
    end
    check_eq("clr_grants", grants, 2);
    check_eq("clr_busy", busy_o, 0);
    check_eq("clr_no_done", done_cnt, 0);
    @(posedge clk);
    #1 ready_pct = 100;
    run_xfer(32'h3000, 32'd4, 4, 100);

`ifdef TCDM_STREAM_LOADER_PERF_EN
    gnt_pct = 100; ready_pct = 100; ready_hold = 8;
    run_xfer(32'h5000, 32'd4, 4, 100);
    check_eq("stall_ge5", stall_cycles >= 5, 1);
    check_eq("stall_model", stall_cycles, stall_model);
    repeat (3) @(posedge clk);
    #1;
    check_eq("stall_hold", stall_cycles, stall_model);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
